// File: rtl/usb_to_uart_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_to_uart_bridge : FIFO-buffered byte path from usb_serial to the UART TX,
//                      with optional LF -> CR LF expansion and drop statistics.
// Revision: 1.0
// ---------------------------------------------------------------------------
module usb_to_uart_bridge #(
   parameter int DEPTH     = 64,
   parameter bit EXPAND_LF = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               in_data,
   input  logic                     in_strobe,
   input  logic                     out_ready,
   output logic [7:0]               out_data,
   output logic                     out_strobe,
   input  logic                     clear_stats,
   output logic                     overflow,
   output logic [15:0]              drop_count,
   output logic [$clog2(DEPTH):0]   fill
);
   localparam int          AW     = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
   localparam logic [7:0]  C_LF   = 8'h0A;
   localparam logic [7:0]  C_CR   = 8'h0D;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      GAP  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] fill_q, fill_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_strobe_q, out_strobe_d;
   logic        pending_lf_q, pending_lf_d;
   logic        overflow_q, overflow_d;
   logic [15:0] drop_count_q, drop_count_d;

   logic [AW:0] count;
   logic        full;
   logic        push;
   logic        drop;
   logic        pop;
   logic [7:0]  rd_byte;

   always_comb begin
      count   = wr_ptr_q - rd_ptr_q;
      full    = (count == C_FULL);
      // A full FIFO drops the write even if a pop frees a slot this cycle.
      push    = in_strobe && !full;
      drop    = in_strobe && full;
      rd_byte = mem_q[rd_ptr_q[AW-1:0]];

      state_d      = state_q;
      out_data_d   = out_data_q;
      out_strobe_d = 1'b0;
      pending_lf_d = pending_lf_q;
      pop          = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (out_ready) begin
               if (pending_lf_q) begin
                  out_data_d   = C_LF;
                  out_strobe_d = 1'b1;
                  pending_lf_d = 1'b0;
                  state_d      = GAP;
               end else if (count != '0) begin
                  pop          = 1'b1;
                  out_strobe_d = 1'b1;
                  state_d      = GAP;
                  if (EXPAND_LF && (rd_byte == C_LF)) begin
                     out_data_d   = C_CR;
                     pending_lf_d = 1'b1;
                  end else begin
                     out_data_d = rd_byte;
                  end
               end
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      wr_ptr_d = wr_ptr_q + (AW+1)'(push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
      fill_d   = wr_ptr_d - rd_ptr_d;

      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      if (clear_stats) begin
         overflow_d   = 1'b0;
         drop_count_d = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fill_q       <= '0;
         out_data_q   <= '0;
         out_strobe_q <= 1'b0;
         pending_lf_q <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fill_q       <= fill_d;
         out_data_q   <= out_data_d;
         out_strobe_q <= out_strobe_d;
         pending_lf_q <= pending_lf_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_strobe = out_strobe_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
   assign fill       = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_to_uart_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_usb_to_uart_bridge : directed vectors for the USB -> UART return path,
//                         one instance with LF expansion and one without.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_usb_to_uart_bridge;
   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_strobe = 1'b0;
   logic        out_ready = 1'b0;
   logic        clear_stats = 1'b0;

   logic [7:0]  out_data1, out_data2;
   logic        out_strobe1, out_strobe2;
   logic        overflow1, overflow2;
   logic [15:0] drop_count1, drop_count2;
   logic [6:0]  fill1, fill2;

   always #5 clk = ~clk;

   usb_to_uart_bridge #(.DEPTH(DEPTH), .EXPAND_LF(1'b1)) u_dut_lf (
      .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
      .out_ready(out_ready), .out_data(out_data1), .out_strobe(out_strobe1),
      .clear_stats(clear_stats), .overflow(overflow1), .drop_count(drop_count1),
      .fill(fill1)
   );

   usb_to_uart_bridge #(.DEPTH(DEPTH), .EXPAND_LF(1'b0)) u_dut_raw (
      .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
      .out_ready(out_ready), .out_data(out_data2), .out_strobe(out_strobe2),
      .clear_stats(clear_stats), .overflow(overflow2), .drop_count(drop_count2),
      .fill(fill2)
   );

   typedef struct {
      logic       strb;
      logic [7:0] din;
      logic       rdy;
      logic       exp_strb;
      logic [7:0] exp_data;
      logic [6:0] exp_fill;
      logic       exp2_strb;
      logic [7:0] exp2_data;
   } vec_t;

   vec_t       vec [14];
   int         n_checks = 0;
   int         n_fail = 0;
   int         cnt1, cnt2, idx1, idx2;
   logic [7:0] exp1_q [$];
   logic [7:0] exp2_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // strb din rdy | strobe data fill (EXPAND_LF=1) | strobe data (EXPAND_LF=0)
      vec[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 7'd1, 1'b0, 8'h00};
      vec[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 7'd0, 1'b1, 8'h41};
      vec[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 7'd0, 1'b0, 8'h41};
      vec[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 7'd0, 1'b0, 8'h41};
      vec[4]  = '{1'b1, 8'h0A, 1'b1, 1'b0, 8'h41, 7'd1, 1'b0, 8'h41};
      vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h0D, 7'd0, 1'b1, 8'h0A};
      vec[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h0D, 7'd0, 1'b0, 8'h0A};
      vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h0A, 7'd0, 1'b0, 8'h0A};
      vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h0A, 7'd0, 1'b0, 8'h0A};
      vec[9]  = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h0A, 7'd1, 1'b0, 8'h0A};
      vec[10] = '{1'b1, 8'h22, 1'b1, 1'b1, 8'h11, 7'd1, 1'b1, 8'h11};
      vec[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 7'd1, 1'b0, 8'h11};
      vec[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 7'd0, 1'b1, 8'h22};
      vec[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 7'd0, 1'b0, 8'h22};

      repeat (3) step();
      chk("reset_strobe", 32'(out_strobe1), 32'd0);
      chk("reset_data", 32'(out_data1), 32'd0);
      chk("reset_fill", 32'(fill1), 32'd0);
      chk("reset_overflow", 32'(overflow1), 32'd0);
      chk("reset_drops", 32'(drop_count1), 32'd0);
      reset = 1'b0;

      // Single byte latency, LF expansion, push+pop on a non-full FIFO
      for (int i = 0; i < 14; i++) begin
         in_strobe = vec[i].strb;
         in_data   = vec[i].din;
         out_ready = vec[i].rdy;
         step();
         chk($sformatf("vec%0d_strobe", i), 32'(out_strobe1), 32'(vec[i].exp_strb));
         chk($sformatf("vec%0d_data", i), 32'(out_data1), 32'(vec[i].exp_data));
         chk($sformatf("vec%0d_fill", i), 32'(fill1), 32'(vec[i].exp_fill));
         chk($sformatf("vec%0d_raw_strobe", i), 32'(out_strobe2), 32'(vec[i].exp2_strb));
         chk($sformatf("vec%0d_raw_data", i), 32'(out_data2), 32'(vec[i].exp2_data));
         chk($sformatf("vec%0d_raw_fill", i), 32'(fill2), 32'(vec[i].exp_fill));
      end
      in_strobe = 1'b0;

      // Overflow with ready low, then drain in order
      out_ready = 1'b0;
      cnt1 = 0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         in_strobe = 1'b1;
         in_data   = 8'(i);
         step();
         if (out_strobe1 || out_strobe2) cnt1++;
      end
      in_strobe = 1'b0;
      chk("ovf_no_strobe_when_not_ready", 32'(cnt1), 32'd0);
      chk("ovf_fill", 32'(fill1), 32'(DEPTH));
      chk("ovf_flag", 32'(overflow1), 32'd1);
      chk("ovf_drops", 32'(drop_count1), 32'd3);
      chk("ovf_raw_drops", 32'(drop_count2), 32'd3);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 10) begin
            exp1_q.push_back(8'h0D);
            exp1_q.push_back(8'h0A);
         end else begin
            exp1_q.push_back(8'(i));
         end
         exp2_q.push_back(8'(i));
      end
      out_ready = 1'b1;
      idx1 = 0;
      idx2 = 0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (out_strobe1) begin
            if (idx1 < exp1_q.size())
               chk($sformatf("drain_lf_byte%0d", idx1), 32'(out_data1), 32'(exp1_q[idx1]));
            idx1++;
         end
         if (out_strobe2) begin
            if (idx2 < exp2_q.size())
               chk($sformatf("drain_raw_byte%0d", idx2), 32'(out_data2), 32'(exp2_q[idx2]));
            idx2++;
         end
      end
      chk("drain_lf_count", 32'(idx1), 32'(DEPTH + 1));
      chk("drain_raw_count", 32'(idx2), 32'(DEPTH));
      chk("drain_fill", 32'(fill1), 32'd0);

      // Full FIFO: a same-cycle pop does not rescue the write
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         in_strobe = 1'b1;
         in_data   = 8'h80 + 8'(i);
         step();
      end
      in_data   = 8'hEE;
      out_ready = 1'b1;
      step();
      in_strobe = 1'b0;
      chk("full_pp_fill", 32'(fill1), 32'(DEPTH - 1));
      chk("full_pp_drops", 32'(drop_count1), 32'd4);
      chk("full_pp_strobe", 32'(out_strobe1), 32'd1);
      chk("full_pp_data", 32'(out_data1), 32'h80);
      cnt1 = 0;
      cnt2 = 0;
      for (int c = 0; c < 140; c++) begin
         step();
         if (out_strobe1) cnt1++;
         if (out_strobe2) cnt2++;
      end
      chk("full_drain_count", 32'(cnt1), 32'(DEPTH - 1));
      chk("full_drain_raw_count", 32'(cnt2), 32'(DEPTH - 1));
      chk("full_drain_last", 32'(out_data1), 32'hBF);
      chk("full_drain_fill", 32'(fill1), 32'd0);

      // Pending LF held across a ready drop
      in_strobe = 1'b1;
      in_data   = 8'h0A;
      step();
      in_strobe = 1'b0;
      step();
      chk("plf_cr_strobe", 32'(out_strobe1), 32'd1);
      chk("plf_cr_data", 32'(out_data1), 32'h0D);
      out_ready = 1'b0;
      cnt1 = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (out_strobe1) cnt1++;
      end
      chk("plf_no_strobe_when_not_ready", 32'(cnt1), 32'd0);
      out_ready = 1'b1;
      step();
      chk("plf_lf_strobe", 32'(out_strobe1), 32'd1);
      chk("plf_lf_data", 32'(out_data1), 32'h0A);
      step();

      // Reset mid-burst with a pending LF
      out_ready = 1'b0;
      foreach (exp2_q[i]) begin
         if (i < 3) begin
            in_strobe = 1'b1;
            in_data   = (i == 0) ? 8'h0A : 8'h30 + 8'(i);
            step();
         end
      end
      in_strobe = 1'b0;
      out_ready = 1'b1;
      step();
      chk("rst_burst_cr", 32'(out_data1), 32'h0D);
      chk("rst_burst_fill", 32'(fill1), 32'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_mid_strobe", 32'(out_strobe1), 32'd0);
      chk("rst_mid_fill", 32'(fill1), 32'd0);
      chk("rst_mid_data", 32'(out_data1), 32'd0);
      cnt1 = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (out_strobe1 || out_strobe2) cnt1++;
      end
      chk("rst_no_further_strobes", 32'(cnt1), 32'd0);
      chk("rst_fill_after", 32'(fill1), 32'd0);

      // Drop counter saturation and clear_stats priority
      out_ready = 1'b0;
      in_strobe = 1'b1;
      in_data   = 8'h55;
      for (int i = 0; i < DEPTH + 65540; i++) step();
      chk("sat_drops", 32'(drop_count1), 32'hFFFF);
      chk("sat_raw_drops", 32'(drop_count2), 32'hFFFF);
      chk("sat_overflow", 32'(overflow1), 32'd1);
      clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
      chk("clr_with_drop_count", 32'(drop_count1), 32'd0);
      chk("clr_with_drop_overflow", 32'(overflow1), 32'd0);
      in_strobe = 1'b0;
      step();
      chk("clr_hold_count", 32'(drop_count1), 32'd0);
      chk("clr_hold_overflow", 32'(overflow1), 32'd0);
      in_strobe = 1'b1;
      step();
      in_strobe = 1'b0;
      chk("post_clr_count", 32'(drop_count1), 32'd1);
      chk("post_clr_overflow", 32'(overflow1), 32'd1);
      chk("post_clr_fill", 32'(fill1), 32'(DEPTH));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
